// File: rtl/uart_frame_rx_pkg.sv
// uart_frame_rx_pkg
// Shared constants and state encoding for the board-state serial link.
// The frame transmitter on the other end of the link uses the same defaults,
// so both sides agree on baud divisor and frame layout.
//   DEF_CLKS_PER_BIT  : clock cycles per bit (25 MHz / 115200)
//   DEF_NUM_BYTES     : bytes per frame
//   DEF_DATA_WIDTH    : useful bits in an assembled frame
//   DEF_TIMEOUT_BITS  : idle bit periods tolerated between bytes of a frame
//   rx_state_t        : receiver FSM states
package uart_frame_rx_pkg;

    localparam int DEF_CLKS_PER_BIT = 217;
    localparam int DEF_NUM_BYTES    = 24;
    localparam int DEF_DATA_WIDTH   = 188;
    localparam int DEF_TIMEOUT_BITS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_GAP
    } rx_state_t;

endpackage

// File: rtl/uart_frame_rx_if.sv
// uart_frame_rx_if
// Bundles the serial line and the frame-level outputs of the receiver.
//   i_Rx_Serial : serial line, idle high (driven by the line side)
//   o_Rx_DV     : one-cycle pulse, complete frame on o_Rx_Data
//   o_Rx_Data   : last complete frame
//   o_Rx_Active : a frame is in progress
//   o_Frame_Err : one-cycle pulse, stop bit low, frame dropped
//   o_Timeout   : one-cycle pulse, inter-byte gap too long, frame dropped
// Modports:
//   master : line driver / frame consumer side
//   slave  : the receiver itself
interface uart_frame_rx_if
    import uart_frame_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  i_Rx_Serial;
    logic                  o_Rx_DV;
    logic [DATA_WIDTH-1:0] o_Rx_Data;
    logic                  o_Rx_Active;
    logic                  o_Frame_Err;
    logic                  o_Timeout;

    modport master (
        output i_Rx_Serial,
        input  o_Rx_DV,
        input  o_Rx_Data,
        input  o_Rx_Active,
        input  o_Frame_Err,
        input  o_Timeout
    );

    modport slave (
        input  i_Rx_Serial,
        output o_Rx_DV,
        output o_Rx_Data,
        output o_Rx_Active,
        output o_Frame_Err,
        output o_Timeout
    );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
// Two-flop synchroniser for the asynchronous serial line. Both flops reset
// to 1 so that the idle-high line never looks like a start bit after reset.
//   i_Clock  : clock, rising edge
//   i_Reset  : asynchronous active-high reset
//   async_in : asynchronous input
//   sync_out : synchronised output, two cycles of latency
module uart_rx_sync (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            meta     <= 1'b1;
            sync_out <= 1'b1;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx
// Multi-byte 8N1 frame receiver. Collects NUM_BYTES bytes (LSB first within
// a byte, byte 0 in the least-significant position) into one DATA_WIDTH-bit
// word; bits of the last byte beyond DATA_WIDTH are dropped.
//   i_Clock : clock, rising edge
//   i_Reset : asynchronous active-high reset
//   rx_bus  : serial line in, frame data and status pulses out
// Parameters:
//   CLKS_PER_BIT : clock cycles per bit
//   NUM_BYTES    : bytes per frame
//   DATA_WIDTH   : assembled word width (must not exceed 8*NUM_BYTES)
//   TIMEOUT_BITS : idle bit periods allowed between bytes of a frame
module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int NUM_BYTES    = DEF_NUM_BYTES,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
    input logic            i_Clock,
    input logic            i_Reset,
    uart_frame_rx_if.slave rx_bus
);

    localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CNT_W        = $clog2(TIMEOUT_CLKS + 1);
    localparam int IDX_W        = $clog2(NUM_BYTES + 1);

    localparam logic [CNT_W-1:0] HALF_BIT    = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL_BIT    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CLKS);
    localparam logic [IDX_W-1:0] LAST_BYTE   = IDX_W'(NUM_BYTES - 1);

    rx_state_t             state;
    logic [CNT_W-1:0]      clk_count;
    logic [2:0]            bit_idx;
    logic [IDX_W-1:0]      byte_idx;
    logic [7:0]            shift_reg;
    logic [DATA_WIDTH-1:0] frame_reg;
    logic [DATA_WIDTH-1:0] frame_merged;
    logic                  stop_failed;
    logic                  rx_line;

    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_dv;
    logic                  rx_active;
    logic                  frame_err;
    logic                  timeout;

    uart_rx_sync u_sync (
        .i_Clock  (i_Clock),
        .i_Reset  (i_Reset),
        .async_in (rx_bus.i_Rx_Serial),
        .sync_out (rx_line)
    );

    // Partial frame with the just-received byte dropped into its slot.
    // Shifting inside a DATA_WIDTH-wide vector discards any bits of the last
    // byte that fall beyond the word, so no explicit bounds test is needed.
    logic [IDX_W+2:0] byte_shift;

    always_comb begin
        byte_shift   = {byte_idx, 3'b000};
        frame_merged = (frame_reg & ~(DATA_WIDTH'(8'hFF) << byte_shift))
                     | (DATA_WIDTH'(shift_reg) << byte_shift);
    end

    // Receiver FSM. The counter is aligned to the middle of the start bit,
    // so each later bit is sampled one full bit period after the previous
    // sample. After a failed stop bit the FSM stays in STOP until the line
    // returns high, so a held-low line cannot be mistaken for a new start.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= ST_IDLE;
            clk_count   <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            shift_reg   <= '0;
            frame_reg   <= '0;
            stop_failed <= 1'b0;
            rx_data     <= '0;
            rx_dv       <= 1'b0;
            rx_active   <= 1'b0;
            frame_err   <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            rx_dv     <= 1'b0;
            frame_err <= 1'b0;
            timeout   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    byte_idx    <= '0;
                    shift_reg   <= '0;
                    clk_count   <= '0;
                    stop_failed <= 1'b0;
                    if (!rx_line) begin
                        state     <= ST_START;
                        rx_active <= 1'b1;
                    end
                end

                ST_START: begin
                    if (clk_count == HALF_BIT) begin
                        clk_count <= '0;
                        if (!rx_line) begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end else if (byte_idx == '0) begin
                            state     <= ST_IDLE;
                            rx_active <= 1'b0;
                        end else begin
                            state <= ST_GAP;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (clk_count == FULL_BIT) begin
                        clk_count          <= '0;
                        shift_reg[bit_idx] <= rx_line;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (stop_failed) begin
                        if (rx_line) begin
                            state <= ST_IDLE;
                        end
                    end else if (clk_count == FULL_BIT) begin
                        clk_count <= '0;
                        if (rx_line) begin
                            frame_reg <= frame_merged;
                            if (byte_idx == LAST_BYTE) begin
                                rx_data   <= frame_merged;
                                rx_dv     <= 1'b1;
                                rx_active <= 1'b0;
                                byte_idx  <= '0;
                                state     <= ST_IDLE;
                            end else begin
                                byte_idx <= byte_idx + 1'b1;
                                state    <= ST_GAP;
                            end
                        end else begin
                            frame_err   <= 1'b1;
                            byte_idx    <= '0;
                            rx_active   <= 1'b0;
                            stop_failed <= 1'b1;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                ST_GAP: begin
                    // Timeout wins over a start edge seen on the same cycle.
                    if (clk_count == TIMEOUT_CNT) begin
                        timeout   <= 1'b1;
                        byte_idx  <= '0;
                        rx_active <= 1'b0;
                        clk_count <= '0;
                        state     <= ST_IDLE;
                    end else if (!rx_line) begin
                        clk_count <= '0;
                        state     <= ST_START;
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_bus.o_Rx_DV     = rx_dv;
    assign rx_bus.o_Rx_Data   = rx_data;
    assign rx_bus.o_Rx_Active = rx_active;
    assign rx_bus.o_Frame_Err = frame_err;
    assign rx_bus.o_Timeout   = timeout;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx
// Self-checking bench for uart_frame_rx at CLKS_PER_BIT = 8. The expected
// word of a frame is simply the concatenated byte stream cut to DATA_WIDTH;
// a compare process checks the outputs on every falling edge.
module tb_uart_frame_rx;

    localparam int CPB   = 8;
    localparam int NB    = 24;
    localparam int DW    = 188;
    localparam int TBITS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_frame_rx_if #(.DATA_WIDTH(DW)) bus ();

    uart_frame_rx #(
        .CLKS_PER_BIT (CPB),
        .NUM_BYTES    (NB),
        .DATA_WIDTH   (DW),
        .TIMEOUT_BITS (TBITS)
    ) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .rx_bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_word = '0;
    int            dv_count   = 0;
    int            err_count  = 0;
    int            tmo_count  = 0;
    logic          prev_dv    = 1'b0;
    logic          prev_err   = 1'b0;
    logic          prev_tmo   = 1'b0;

    task automatic checkOutput(input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Byte i of the frame sits at [8*i +: 8]; byte i = first + i*step.
    function automatic logic [8*NB-1:0] makeFrame(input logic [7:0] first,
                                                  input logic [7:0] step);
        logic [8*NB-1:0] v;
        v = '0;
        for (int i = 0; i < NB; i++) begin
            v[8*i +: 8] = first + 8'(i) * step;
        end
        return v;
    endfunction

    // One 8N1 byte on the line, starting and ending on a falling edge.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        bus.i_Rx_Serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.i_Rx_Serial = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.i_Rx_Serial = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    // Sends the first nbytes of a frame back to back; a complete frame is
    // queued as an expected word.
    task automatic sendFrame(input logic [8*NB-1:0] f, input int nbytes);
        logic [DW-1:0] w;
        if (nbytes == NB) begin
            w = f[DW-1:0];
            exp_q.push_back(w);
        end
        for (int i = 0; i < nbytes; i++) begin
            applyStimulus(f[8*i +: 8], 1'b1);
        end
    endtask

    task automatic waitDv(input int target);
        for (int c = 0; c < 200 && dv_count < target; c++) @(negedge clk);
        checkOutput("dv_arrived", DW'(dv_count), DW'(target));
    endtask

    // Compare process: outputs against the frame model on every cycle.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("reset_flags", DW'({bus.o_Rx_DV, bus.o_Rx_Active,
                                            bus.o_Frame_Err, bus.o_Timeout}), '0);
            checkOutput("reset_data", bus.o_Rx_Data, '0);
            model_word = '0;
            prev_dv    = 1'b0;
            prev_err   = 1'b0;
            prev_tmo   = 1'b0;
        end else begin
            if (bus.o_Rx_DV) begin
                checkOutput("dv_has_expected", DW'(exp_q.size() > 0), DW'(1));
                if (exp_q.size() > 0) model_word = exp_q.pop_front();
                checkOutput("frame_data", bus.o_Rx_Data, model_word);
                dv_count++;
            end else begin
                checkOutput("data_hold", bus.o_Rx_Data, model_word);
            end
            if (bus.o_Frame_Err) err_count++;
            if (bus.o_Timeout) tmo_count++;
            checkOutput("pulse_exclusive",
                        DW'($countones({bus.o_Rx_DV, bus.o_Frame_Err, bus.o_Timeout}) <= 1),
                        DW'(1));
            if (bus.o_Rx_DV || bus.o_Frame_Err || bus.o_Timeout)
                checkOutput("active_drop", DW'(bus.o_Rx_Active), '0);
            checkOutput("pulse_width", DW'({bus.o_Rx_DV & prev_dv,
                                            bus.o_Frame_Err & prev_err,
                                            bus.o_Timeout & prev_tmo}), '0);
            prev_dv  = bus.o_Rx_DV;
            prev_err = bus.o_Frame_Err;
            prev_tmo = bus.o_Timeout;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [8*NB-1:0] f;
        logic [DW-1:0]   w;
        logic [DW-1:0]   first_word;

        bus.i_Rx_Serial = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset_active", DW'(bus.o_Rx_Active), '0);
        #2 rst = 1'b0;
        @(negedge clk);
        repeat (4 * CPB) @(negedge clk);

        // Full frame 0x00..0x17
        f = makeFrame(8'h00, 8'h01);
        first_word = f[DW-1:0];
        sendFrame(f, NB);
        waitDv(1);
        w = bus.o_Rx_Data;
        checkOutput("lit_byte0", DW'(w[7:0]), DW'(8'h00));
        checkOutput("lit_byte1", DW'(w[15:8]), DW'(8'h01));
        checkOutput("lit_top_nibble", DW'(w[187:184]), DW'(4'h7));

        // Short glitch in IDLE
        bus.i_Rx_Serial = 1'b0;
        repeat (3) @(negedge clk);
        bus.i_Rx_Serial = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checkOutput("glitch_active", DW'(bus.o_Rx_Active), '0);
        checkOutput("glitch_no_pulse", DW'(dv_count + err_count + tmo_count), DW'(1));

        // Framing error on byte 5, then a clean frame
        f = makeFrame(8'h40, 8'h03);
        for (int i = 0; i < 5; i++) applyStimulus(f[8*i +: 8], 1'b1);
        applyStimulus(f[47:40], 1'b0);
        bus.i_Rx_Serial = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checkOutput("err_count", DW'(err_count), DW'(1));
        checkOutput("err_no_dv", DW'(dv_count), DW'(1));
        checkOutput("err_data_kept", bus.o_Rx_Data, first_word);
        checkOutput("err_active", DW'(bus.o_Rx_Active), '0);
        f = makeFrame(8'h30, 8'h07);
        sendFrame(f, NB);
        waitDv(2);

        // Inter-byte timeout after 10 bytes, then a clean frame
        f = makeFrame(8'h11, 8'h0B);
        sendFrame(f, 10);
        repeat (TBITS * CPB + 2 * CPB) @(negedge clk);
        checkOutput("tmo_count", DW'(tmo_count), DW'(1));
        checkOutput("tmo_no_dv", DW'(dv_count), DW'(2));
        checkOutput("tmo_active", DW'(bus.o_Rx_Active), '0);
        f = makeFrame(8'hC0, 8'h05);
        sendFrame(f, NB);
        waitDv(3);

        // Reset during byte 12, then a clean frame
        sendFrame(f, 12);
        bus.i_Rx_Serial = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        checkOutput("active_midframe", DW'(bus.o_Rx_Active), DW'(1));
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_async_flags", DW'({bus.o_Rx_DV, bus.o_Rx_Active,
                                            bus.o_Frame_Err, bus.o_Timeout}), '0);
        checkOutput("rst_async_data", bus.o_Rx_Data, '0);
        repeat (3) @(negedge clk);
        bus.i_Rx_Serial = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        repeat (4 * CPB) @(negedge clk);
        f = makeFrame(8'h7E, 8'hF1);
        sendFrame(f, NB);
        waitDv(4);

        // Back-to-back frames, no idle between them
        sendFrame(makeFrame(8'hA5, 8'h00), NB);
        sendFrame(makeFrame(8'h5A, 8'h00), NB);
        waitDv(6);
        w = bus.o_Rx_Data;
        checkOutput("lit_5a_byte0", DW'(w[7:0]), DW'(8'h5A));
        checkOutput("lit_5a_top_nibble", DW'(w[187:184]), DW'(4'hA));

        repeat (4 * CPB) @(negedge clk);
        checkOutput("final_dv", DW'(dv_count), DW'(6));
        checkOutput("final_err", DW'(err_count), DW'(1));
        checkOutput("final_tmo", DW'(tmo_count), DW'(1));
        checkOutput("final_queue", DW'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
